demux_stream: RTL

Registered 1-to-2 stream demultiplexer: the write-side counterpart of the 32-bit 2:1 selector. It accepts one `WIDTH`-bit word per cycle with a route select and forwards it to output port A or B over valid/ready handshakes. Two-entry internal buffering sustains full throughput under backpressure. It sits between a producer, such as the datapath write-back bus, and two consumers, such as register-file/memory write ports or two peripherals. Each output port has a per-port transfer counter for debug.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_stream_if.sv | 25 ++
 rtl/demux_stream_skid_fifo2.sv | 67 ++++++
 rtl/demux_stream.sv | 57 +++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_stream_if.sv
// Producer-side and two consumer-side valid/ready handshakes of the demultiplexer.
interface demux_stream_if import demux_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_a_data;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [WIDTH-1:0] out_b_data;

    modport slave (
        input  in_valid, in_sel, in_data, out_a_ready, out_b_ready,
        output in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
    );

    modport master (
        output in_valid, in_sel, in_data, out_a_ready, out_b_ready,
        input  in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
    );
endinterface

// File: rtl/demux_stream_skid_fifo2.sv
// Generic 2-entry in-order FIFO, 1-cycle write-to-read latency, full rate under backpressure.
// wr_ready is registered (next occupancy != FULL), so there is no rd_ready -> wr_ready path.
module skid_fifo2 import demux_pkg::*; #(
    parameter int DW = WIDTH_DEF + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data
);
    occ_t          occ;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          push;
    logic          pop;

    assign push     = wr_valid && wr_ready;
    assign rd_valid = (occ != OCC_EMPTY);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= OCC_EMPTY;
            head     <= '0;
            tail     <= '0;
            wr_ready <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    wr_ready <= 1'b1;
                    if (push) begin
                        head <= wr_data;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    wr_ready <= !(push && !pop);
                    if (push && pop) begin
                        head <= wr_data;
                    end else if (push) begin
                        tail <= wr_data;
                        occ  <= OCC_FULL;
                    end else if (pop) begin
                        occ  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // No push is possible here: wr_ready was already low.
                    wr_ready <= pop;
                    if (pop) begin
                        head <= tail;
                        occ  <= OCC_ONE;
                    end
                end
                default: begin
                    occ      <= OCC_EMPTY;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demux: word accepted at edge N shows on its port at N+1.
// Head-of-line blocking, in-order; in_ready registered, full rate with ready held high.
module demux_stream import demux_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_stream_if.slave    io,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH:0] rd_data;
    logic           rd_valid;
    logic           rd_ready;
    logic           head_sel;
    logic           a_fire;
    logic           b_fire;

    skid_fifo2 #(.DW(WIDTH + 1)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (io.in_valid),
        .wr_ready (io.in_ready),
        .wr_data  ({io.in_sel, io.in_data}),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data)
    );

    assign head_sel       = rd_data[WIDTH];
    assign io.out_a_valid = rd_valid && (head_sel == SEL_A);
    assign io.out_b_valid = rd_valid && (head_sel == SEL_B);
    assign io.out_a_data  = rd_data[WIDTH-1:0];
    assign io.out_b_data  = rd_data[WIDTH-1:0];

    // Only the port the head is routed to may release it.
    assign rd_ready = (head_sel == SEL_B) ? io.out_b_ready : io.out_a_ready;
    assign a_fire   = io.out_a_valid && io.out_a_ready;
    assign b_fire   = io.out_b_valid && io.out_b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (clr_cnt) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_fire) cnt_a <= cnt_a + CNT_ONE;
            if (b_fire) cnt_b <= cnt_b + CNT_ONE;
        end
    end
endmodule
